seg7_scan_capture: RTL and testbench

- Receive-side counterpart of the team's 7-segment display path.
- Monitors a multiplexed 7-segment display bus: one 8-bit segment pattern plus one-hot digit-select lines.
- Debounces each digit period, decodes each segment pattern back to a 4-bit value, and assembles a full frame of DIGITS values.
- Used in-system for display self-check and by benches as a scoreboard front end for display drivers.

---
 rtl/seg7_scan_capture.sv | 221 ++++++++++++++++++++++
 tb/tb_seg7_scan_capture.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_capture.sv
// seg7_scan_capture
//   Receive-side monitor for a multiplexed 7-segment display bus. Each digit
//   period is debounced and decoded back to a 4-bit value. The values are
//   collected into a frame of DIGITS values, and the frame is published
//   atomically once every digit position has been seen.
//
// Optional feature macro: SEG7_HEX_DECODE_EN
//   When defined, the decode table also accepts the hex glyphs A, b, C, d, E
//   and F. When undefined, those glyphs are flagged as decode errors.
//
// Ports
//   clk         in   rising-edge clock
//   rst         in   synchronous active-high reset
//   seg_in      in   8  segment pattern, bit0=a .. bit6=g, bit7=dp
//   dig_sel     in   DIGITS  one-hot digit enables
//   digits_out  out  4*DIGITS  decoded values, digit i at [4i+3:4i]
//   dp_out      out  DIGITS  captured decimal point per digit
//   blank_out   out  DIGITS  digit pattern was all-off
//   digit_err   out  DIGITS  digit pattern not in the decode table
//   frame_valid out  one-cycle pulse when a new frame lands on the outputs
//   lost        out  level, no capture for TIMEOUT cycles
module seg7_scan_capture #(
    parameter int DIGITS  = 4,
    parameter int STABLE  = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            seg_in,
    input  logic [DIGITS-1:0]     dig_sel,
    output logic [4*DIGITS-1:0]   digits_out,
    output logic [DIGITS-1:0]     dp_out,
    output logic [DIGITS-1:0]     blank_out,
    output logic [DIGITS-1:0]     digit_err,
    output logic                  frame_valid,
    output logic                  lost
);

    localparam int          SW      = 8 + DIGITS;
    localparam logic [7:0]  CAP_AT  = 8'(STABLE - 1);
    localparam logic [15:0] TMO_MAX = 16'(TIMEOUT);

    localparam logic [1:0] S_HUNT    = 2'd0;
    localparam logic [1:0] S_COLLECT = 2'd1;
    localparam logic [1:0] S_EMIT    = 2'd2;

    // Returns {err, blank, value[3:0]}.
    function automatic logic [5:0] decode7(input logic [6:0] p);
        logic [5:0] r;
        case (p)
            7'h3F:   r = 6'h00;
            7'h06:   r = 6'h01;
            7'h5B:   r = 6'h02;
            7'h4F:   r = 6'h03;
            7'h66:   r = 6'h04;
            7'h6D:   r = 6'h05;
            7'h7D:   r = 6'h06;
            7'h07:   r = 6'h07;
            7'h7F:   r = 6'h08;
            7'h6F:   r = 6'h09;
            7'h00:   r = 6'b01_0000;
`ifdef SEG7_HEX_DECODE_EN
            7'h77:   r = 6'h0A;
            7'h7C:   r = 6'h0B;
            7'h39:   r = 6'h0C;
            7'h5E:   r = 6'h0D;
            7'h79:   r = 6'h0E;
            7'h71:   r = 6'h0F;
`endif
            default: r = 6'b10_0000;
        endcase
        return r;
    endfunction

    logic [SW-1:0]       smp_q, prev_q;
    logic [7:0]          cnt_q, cnt_d;
    logic                armed_q, armed_d;
    logic [15:0]         tmo_q, tmo_d;
    logic [1:0]          state_q, state_d;
    logic [DIGITS-1:0]   mask_q, mask_d;

    logic [4*DIGITS-1:0] sh_val_q;
    logic [DIGITS-1:0]   sh_dp_q, sh_blank_q, sh_err_q;

    logic [4*DIGITS-1:0] digits_q;
    logic [DIGITS-1:0]   dp_q, blank_q, err_q;
    logic                fv_q;

    logic [7:0]          smp_seg;
    logic [DIGITS-1:0]   smp_sel;
    logic                eq, sel_onehot, cap, accept, emit, lost_rise;
    logic [5:0]          dec;

    assign smp_seg    = smp_q[SW-1:DIGITS];
    assign smp_sel    = smp_q[DIGITS-1:0];
    assign eq         = (smp_q == prev_q);
    assign sel_onehot = (smp_sel != '0) && ((smp_sel & (smp_sel - DIGITS'(1))) == '0);
    assign dec        = decode7(smp_seg[6:0]);

    // Debounce: a capture fires on the cycle the run of identical samples
    // reaches STABLE, and only once per run (armed clears until the bus moves).
    always_comb begin
        cnt_d   = cnt_q;
        armed_d = armed_q;
        cap     = 1'b0;
        if (eq) begin
            if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
            if (armed_q && (cnt_d == CAP_AT) && sel_onehot) begin
                cap     = 1'b1;
                armed_d = 1'b0;
            end
        end else begin
            cnt_d   = 8'd0;
            armed_d = 1'b1;
        end
    end

    always_comb begin
        tmo_d = tmo_q;
        if (cap)                 tmo_d = 16'd0;
        else if (tmo_q != TMO_MAX) tmo_d = tmo_q + 16'd1;
    end

    assign lost_rise = (tmo_d == TMO_MAX) && (tmo_q != TMO_MAX);

    // Frame assembly. EMIT is the single cycle between the completing capture
    // and the atomic copy of the shadow into the output registers.
    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        accept  = 1'b0;
        emit    = 1'b0;
        case (state_q)
            S_HUNT: begin
                if (cap && smp_sel[0]) begin
                    accept  = 1'b1;
                    mask_d  = DIGITS'(1);
                    state_d = S_COLLECT;
                end
            end
            S_COLLECT: begin
                if (cap) begin
                    accept = 1'b1;
                    if (smp_sel[0]) mask_d = DIGITS'(1);
                    else            mask_d = mask_q | smp_sel;
                    if (&mask_d)    state_d = S_EMIT;
                end
            end
            S_EMIT: begin
                emit    = 1'b1;
                mask_d  = '0;
                state_d = S_HUNT;
            end
            default: begin
                mask_d  = '0;
                state_d = S_HUNT;
            end
        endcase
        if (lost_rise) begin
            state_d = S_HUNT;
            mask_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            smp_q   <= '0;
            prev_q  <= '0;
            cnt_q   <= 8'd0;
            armed_q <= 1'b1;
            tmo_q   <= 16'd0;
            state_q <= S_HUNT;
            mask_q  <= '0;
            fv_q    <= 1'b0;
        end else begin
            smp_q   <= {seg_in, dig_sel};
            prev_q  <= smp_q;
            cnt_q   <= cnt_d;
            armed_q <= armed_d;
            tmo_q   <= tmo_d;
            state_q <= state_d;
            mask_q  <= mask_d;
            fv_q    <= emit;
        end
    end

    // Shadow slots need no reset: they only become visible through emit,
    // which requires every slot to have been written since the last HUNT.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DIGITS; i++) begin
            if (accept && smp_sel[i]) begin
                sh_val_q[4*i +: 4] <= dec[3:0];
                sh_dp_q[i]         <= smp_seg[7];
                sh_blank_q[i]      <= dec[4];
                sh_err_q[i]        <= dec[5];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            digits_q <= '0;
            dp_q     <= '0;
            blank_q  <= '0;
            err_q    <= '0;
        end else if (emit) begin
            digits_q <= sh_val_q;
            dp_q     <= sh_dp_q;
            blank_q  <= sh_blank_q;
            err_q    <= sh_err_q;
        end
    end

    assign digits_out  = digits_q;
    assign dp_out      = dp_q;
    assign blank_out   = blank_q;
    assign digit_err   = err_q;
    assign frame_valid = fv_q;
    assign lost        = (tmo_q == TMO_MAX);

endmodule

// File: tb/tb_seg7_scan_capture.sv
// Testbench for seg7_scan_capture: directed scenarios plus randomized digit
// periods, checked against a period-level reference model.
module tb_seg7_scan_capture;

    localparam int DIGITS  = 4;
    localparam int STABLE  = 4;
    localparam int TIMEOUT = 64;
    localparam int FW      = 7 * DIGITS;
`ifdef SEG7_HEX_DECODE_EN
    localparam bit HEX = 1'b1;
`else
    localparam bit HEX = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                rst;
    logic [7:0]          seg_in;
    logic [DIGITS-1:0]   dig_sel;
    logic [4*DIGITS-1:0] digits_out;
    logic [DIGITS-1:0]   dp_out, blank_out, digit_err;
    logic                frame_valid, lost;

    seg7_scan_capture #(.DIGITS(DIGITS), .STABLE(STABLE), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .seg_in(seg_in), .dig_sel(dig_sel),
        .digits_out(digits_out), .dp_out(dp_out), .blank_out(blank_out),
        .digit_err(digit_err), .frame_valid(frame_valid), .lost(lost)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [6:0] pat_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    // {err, blank, value}
    function automatic logic [5:0] ref_decode(input logic [6:0] p);
        if (p == 7'h00) return 6'b01_0000;
        for (int v = 0; v < 16; v++)
            if (pat_tab[v] == p && (v < 10 || HEX)) return {2'b00, 4'(v)};
        return 6'b10_0000;
    endfunction

    bit                m_collect;
    logic [DIGITS-1:0] m_mask;
    logic [FW-1:0]     m_shadow;
    logic [FW-1:0]     exp_q[$];
    logic [FW-1:0]     shown;
    int                n_model_frames = 0;
    int                n_pulses = 0;
    int                pulse_cyc = 0;

    wire [FW-1:0] dut_frame = {digits_out, dp_out, blank_out, digit_err};

    task automatic model_reset();
        m_collect = 0;
        m_mask    = '0;
        exp_q.delete();
        shown     = '0;
    endtask

    task automatic model_capture(input int d, input logic [7:0] seg);
        logic [5:0] dv;
        dv = ref_decode(seg[6:0]);
        if (!m_collect) begin
            if (d != 0) return;
            m_collect = 1;
        end
        if (d == 0) m_mask = '0;
        m_mask[d] = 1'b1;
        m_shadow[3*DIGITS + 4*d +: 4] = dv[3:0];
        m_shadow[2*DIGITS + d]        = seg[7];
        m_shadow[DIGITS + d]          = dv[4];
        m_shadow[d]                   = dv[5];
        if (&m_mask) begin
            exp_q.push_back(m_shadow);
            n_model_frames++;
            m_collect = 0;
            m_mask    = '0;
        end
    endtask

    function automatic int sel_index(input logic [DIGITS-1:0] s);
        for (int i = 0; i < DIGITS; i++) if (s[i]) return i;
        return 0;
    endfunction

    // A period of L cycles with constant pins captures iff it lasts at least
    // STABLE samples and selects exactly one digit.
    int last_drive = 0;
    task automatic drive_period(input logic [7:0] seg, input logic [DIGITS-1:0] sel, input int len);
        if (exp_q.size() == 0) chk("hold_outputs", dut_frame, shown);
        seg_in     = seg;
        dig_sel    = sel;
        last_drive = cyc;
        if (len >= STABLE && $onehot(sel)) model_capture(sel_index(sel), seg);
        repeat (len) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    always @(negedge clk) begin
        if (!rst && frame_valid) begin
            n_pulses++;
            pulse_cyc = cyc;
            chk("frame_expected", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) begin
                shown = exp_q.pop_front();
                chk("frame", dut_frame, shown);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int p0, t3, noncap;
        logic [7:0] s, ps;
        logic [DIGITS-1:0] sl, psl;
        int len;

        rst = 1'b1; seg_in = 8'h00; dig_sel = '0;
        repeat (3) @(posedge clk);
        #1;
        do_reset();
        chk("rst_digits", digits_out, 0);
        chk("rst_flags", {dp_out, blank_out, digit_err}, 0);
        chk("rst_fv_lost", {frame_valid, lost}, 0);

        // basic frame and latency
        p0 = n_pulses;
        drive_period(8'h3F, 4'b0001, 8);
        drive_period(8'h06, 4'b0010, 8);
        drive_period(8'h5B, 4'b0100, 8);
        drive_period(8'h4F, 4'b1000, 8);
        t3 = last_drive;
        drive_period(8'h00, 4'b0000, 8);
        chk("basic_pulses", n_pulses - p0, 1);
        chk("basic_digits", digits_out, 16'h3210);
        chk("basic_err_blank", {digit_err, blank_out}, 0);
        chk("latency", pulse_cyc - t3, STABLE + 2);

        // glitch on digit 2 is not captured
        p0 = n_pulses;
        drive_period(8'h3F, 4'b0001, 8);
        drive_period(8'h06, 4'b0010, 8);
        drive_period(8'h7F, 4'b0100, 2);
        drive_period(8'h6D, 4'b0100, 8);
        drive_period(8'h4F, 4'b1000, 8);
        drive_period(8'h00, 4'b0000, 8);
        chk("glitch_pulses", n_pulses - p0, 1);
        chk("glitch_digits", digits_out, 16'h3510);

        // decimal point and blank
        drive_period(8'h3F, 4'b0001, 8);
        drive_period(8'h86, 4'b0010, 8);
        drive_period(8'h5B, 4'b0100, 8);
        drive_period(8'h00, 4'b1000, 8);
        drive_period(8'h01, 4'b0000, 8);
        chk("dp_out", dp_out, 4'b0010);
        chk("dp_digit1", digits_out[7:4], 4'd1);
        chk("blank_out", blank_out, 4'b1000);

        // hex glyph on digit 0
        drive_period(8'h77, 4'b0001, 8);
        drive_period(8'h06, 4'b0010, 8);
        drive_period(8'h5B, 4'b0100, 8);
        drive_period(8'h4F, 4'b1000, 8);
        drive_period(8'h00, 4'b0000, 8);
        chk("hex_value", digits_out[3:0], HEX ? 4'hA : 4'h0);
        chk("hex_err", digit_err[0], HEX ? 1'b0 : 1'b1);

        // scan starting mid-frame
        p0 = n_pulses;
        drive_period(8'h5B, 4'b0100, 8);
        drive_period(8'h4F, 4'b1000, 8);
        drive_period(8'h3F, 4'b0001, 8);
        drive_period(8'h06, 4'b0010, 8);
        chk("hunt_no_early", n_pulses - p0, 0);
        drive_period(8'h6D, 4'b0100, 8);
        drive_period(8'h7D, 4'b1000, 8);
        drive_period(8'h00, 4'b0000, 8);
        chk("hunt_pulses", n_pulses - p0, 1);
        chk("hunt_digits", digits_out, 16'h6510);

        // randomized periods
        ps = 8'h00; psl = '0; noncap = 0;
        for (int k = 0; k < 300; k++) begin
            do begin
                int r;
                r = $urandom_range(99);
                if (r < 70)      s = {1'($urandom), pat_tab[$urandom_range(15)]};
                else if (r < 85) s = {1'($urandom), 7'h00};
                else             s = 8'($urandom);
                r = $urandom_range(99);
                if (r < 80 || noncap > 24) sl = DIGITS'(1) << $urandom_range(DIGITS - 1);
                else                       sl = DIGITS'($urandom);
                len = (noncap > 24) ? $urandom_range(10, STABLE) : $urandom_range(10, 1);
            end while ({s, sl} == {ps, psl});
            if (len >= STABLE && $onehot(sl)) noncap = 0;
            else                              noncap += len;
            drive_period(s, sl, len);
            ps = s; psl = sl;
        end
        drive_period(8'hFF, 4'b0000, 10);
        chk("rand_frames", n_pulses, n_model_frames);
        chk("rand_queue_empty", exp_q.size(), 0);

        // timeout drops a partial frame and raises lost
        p0 = n_pulses;
        drive_period(8'h3F, 4'b0001, 8);
        drive_period(8'h3F, 4'b0000, TIMEOUT + 5);
        chk("lost_set", lost, 1'b1);
        m_collect = 0;
        m_mask    = '0;
        drive_period(8'h06, 4'b0010, 8);
        chk("lost_clear", lost, 1'b0);
        drive_period(8'h5B, 4'b0100, 8);
        drive_period(8'h4F, 4'b1000, 8);
        drive_period(8'h00, 4'b0000, 8);
        chk("lost_no_frame", n_pulses - p0, 0);

        // reset mid-frame
        drive_period(8'h3F, 4'b0001, 8);
        drive_period(8'h06, 4'b0010, 8);
        drive_period(8'h5B, 4'b0100, 8);
        drive_period(8'h4F, 4'b1000, 8);
        drive_period(8'h66, 4'b0001, 8);
        drive_period(8'h6D, 4'b0010, 8);
        chk("pre_rst_digits", digits_out, 16'h3210);
        do_reset();
        chk("midrst_digits", digits_out, 0);
        chk("midrst_flags", {dp_out, blank_out, digit_err, frame_valid, lost}, 0);
        p0 = n_pulses;
        drive_period(8'h06, 4'b0010, 8);
        drive_period(8'h5B, 4'b0100, 8);
        drive_period(8'h4F, 4'b1000, 8);
        drive_period(8'h00, 4'b0000, 8);
        chk("midrst_discard", n_pulses - p0, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
